// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mcp_pkg : shared encodings for the multicycle MIPS control unit
// Rev 1.0
// ---------------------------------------------------------------------------
package mcp_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_controller_if : IR fields / flags in, datapath control out
// Rev 1.0
// ---------------------------------------------------------------------------
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal_op, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal_op, state_o
  );
endinterface
`default_nettype wire

// File: rtl/mc_controller_alu_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_dec : alu_op / funct to ALU control, purely combinational
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_dec
  import mcp_pkg::*;
(
  input  wire logic [5:0] i_funct,
  input  wire logic [1:0] i_alu_op,
  output logic      [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALUC_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct quietly falls back to add
        case (i_funct)
          FN_SUB:  o_alu_control = ALUC_SUB;
          FN_AND:  o_alu_control = ALUC_AND;
          FN_OR:   o_alu_control = ALUC_OR;
          FN_SLT:  o_alu_control = ALUC_SLT;
          default: o_alu_control = ALUC_ADD;
        endcase
      end
      default: o_alu_control = ALUC_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_controller : multicycle MIPS control FSM with memory-ready handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module mc_controller
  import mcp_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  mc_controller_if.master  bus
);

  localparam logic [3:0] S_FETCH   = ST_FETCH;
  localparam logic [3:0] S_DECODE  = ST_DECODE;
  localparam logic [3:0] S_MEMADR  = ST_MEMADR;
  localparam logic [3:0] S_MEMRD   = ST_MEMRD;
  localparam logic [3:0] S_MEMWB   = ST_MEMWB;
  localparam logic [3:0] S_MEMWR   = ST_MEMWR;
  localparam logic [3:0] S_EXECUTE = ST_EXECUTE;
  localparam logic [3:0] S_ALUWB   = ST_ALUWB;
  localparam logic [3:0] S_BRANCH  = ST_BRANCH;
  localparam logic [3:0] S_ADDIEX  = ST_ADDIEX;
  localparam logic [3:0] S_ADDIWB  = ST_ADDIWB;
  localparam logic [3:0] S_JUMP    = ST_JUMP;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_mem_ready;
  logic       w_valid;
  logic       w_pc_write, w_branch;
  logic       w_iord, w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write;
  logic       w_alu_src_a, w_illegal;
  logic [1:0] w_alu_src_b, w_pc_src, w_alu_op;
  logic [2:0] w_alu_control;

  assign w_mem_ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_iord       = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_alu_op     = ALUOP_ADD;
    w_pc_src     = PCSRC_ALU;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = w_mem_ready;
        w_pc_write  = w_mem_ready;
        w_next      = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMMSH2;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        // Strobe stays up across every wait cycle so the memory sees a steady request
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = w_mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALUOP_SUB;
        w_pc_src    = PCSRC_ALUOUT;
        w_branch    = 1'b1;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_src   = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  alu_dec u_alu_dec (
    .i_funct       (bus.funct),
    .i_alu_op      (w_alu_op),
    .o_alu_control (w_alu_control)
  );

  // Reset and unreachable encodings both blank every control output
  assign w_valid = reset_n && (r_state <= S_JUMP);

  assign bus.iord        = w_valid & w_iord;
  assign bus.mem_write   = w_valid & w_mem_write;
  assign bus.ir_write    = w_valid & w_ir_write;
  assign bus.reg_dst     = w_valid & w_reg_dst;
  assign bus.mem_to_reg  = w_valid & w_mem_to_reg;
  assign bus.reg_write   = w_valid & w_reg_write;
  assign bus.alu_src_a   = w_valid & w_alu_src_a;
  assign bus.alu_src_b   = w_valid ? w_alu_src_b : 2'b00;
  assign bus.alu_control = w_valid ? w_alu_control : 3'b000;
  assign bus.pc_src      = w_valid ? w_pc_src : 2'b00;
  assign bus.pc_en       = w_valid & (w_pc_write | (w_branch & bus.zero));
  assign bus.illegal_op  = w_valid & w_illegal;
  assign bus.state_o     = reset_n ? r_state : 4'd0;

endmodule
`default_nettype wire
